snake_engine: RTL
=================

Name: snake_engine

Overview:
- Game-logic stage of the Snake design. It drives the VGA renderer with the packed worm segment arrays, the item cell and the worm length.
- On each move tick it advances the worm one cell on a 64x48 grid, following the player's direction.
- It detects item eating (growth), wall collisions and self collisions, and places new items with an LFSR.
- It runs on the 50 MHz system clock.

Parameters:
- MAX_LEN, 64: maximum worm length in segments; the packed arrays are 6*MAX_LEN bits.
- TICK_DIV, 5000000: clock cycles per move tick (10 moves/s at 50 MHz).
- GRID_W, 64: grid columns; x range 0..GRID_W-1.
- GRID_H, 48: grid rows; y range 0..GRID_H-1.

Ports:
- i_Clk, input, 1: system clock.
- i_Rst, input, 1: synchronous active-high reset.
- i_start, input, 1: one-cycle pulse; IDLE->RUN, or OVER->IDLE.
- i_btn_up, i_btn_down, i_btn_left, i_btn_right, input, 1 each: debounced one-cycle direction pulses.
- o_worm_x, output, 6*MAX_LEN: segment x coordinates; segment k is at [6k+:6], segment 0 is the head.
- o_worm_y, output, 6*MAX_LEN: segment y coordinates, same packing.
- o_item_x, output, 6: item column.
- o_item_y, output, 6: item row.
- o_size, output, 10: current worm length.
- o_score, output, 10: items eaten since the last restart.
- o_game_over, output, 1: high while in OVER.

Behaviour:
- One clock domain. Reset is synchronous and active-high on i_Rst, sampled on the i_Clk rising edge. Reset overrides all other inputs in the same cycle, including mid-move and mid-PLACE.
- Reset and IDLE-entry values:
  - Segments 0..2 = (32,24), (31,24), (30,24); all other segments = (0,0).
  - o_size = 3, o_score = 0, direction = RIGHT.
  - Item = (48,24), LFSR = 12'hACE, tick counter = 0, o_game_over = 0, state = IDLE.
  - The LFSR seed is applied only on i_Rst, not on IDLE entry.
- Direction encoding: RIGHT = x+1, LEFT = x-1, UP = y-1, DOWN = y+1.
- LFSR: 12-bit Fibonacci, taps 12,11,10,4. It steps every cycle in every state.
- States:
  - IDLE: outputs hold. i_start -> RUN.
  - RUN: the tick counter counts 0..TICK_DIV-1. When it is at TICK_DIV-1, it wraps to 0 and a move executes in that cycle.
  - PLACE: the tick counter is frozen. Every cycle, the candidate item is taken from the LFSR:
    - x = lfsr[5:0];
    - y = lfsr[11:6] if that is < 48, else lfsr[11:6] - 16.
    - If the candidate matches no segment 0..o_size-1, it is latched as the item and the state goes to RUN. Otherwise the state stays in PLACE.
  - OVER: o_game_over = 1 and all other outputs freeze. i_start -> IDLE, which reloads the IDLE values.
- Direction request:
  - A button pulse latches a pending direction, which is applied at the next move.
  - A request opposite to the direction in use for the current move is ignored.
  - The last pulse before the tick wins. If several buttons pulse in the same cycle, priority is up > down > left > right.
- Move, all computed in one cycle:
  - new_head = head + direction.
  - wall = new_head is outside 0..63 or 0..47. Check before truncation: x=0 moving LEFT is a wall hit; y=47 moving DOWN is a wall hit.
  - eat = (new_head == item).
  - grow = eat and o_size < MAX_LEN.
  - self = new_head matches any segment 0..o_size-2. When grow is set, segment o_size-1 is also checked.
  - If wall or self: go to OVER. Body, size and score are unchanged.
  - Otherwise, shift segments k <- k-1 for k = 1..MAX_LEN-1 and set segment 0 = new_head.
    - If grow: o_size += 1; the new last segment is the old tail.
    - If not grow: segments at index >= o_size are don't-care to the renderer but are kept as shifted values.
  - If eat: o_score += 1, saturating at 1023, and the state goes to PLACE, even when o_size == MAX_LEN (length stays at MAX_LEN).
- Latency: body outputs change on the cycle after the tick cycle. The item updates 1+ cycles after the eat move.
- i_start in RUN or PLACE is ignored. Button pulses in IDLE or OVER are ignored, and the pending direction resets to RIGHT on IDLE entry.

Test Plan:
- Reset, then check outputs: head (32,24), o_size = 3, item (48,24), o_game_over = 0, state IDLE. With no i_start for 100 cycles, nothing changes.
- TICK_DIV = 4: i_start, then 3 ticks -> head (35,24), segments 1 and 2 at (34,24) and (33,24). An i_btn_left pulse is ignored, so the head reaches (36,24) after the next tick.
- Steer until new_head == item -> o_size 3->4, o_score = 1, state enters PLACE. The new item does not overlap the body, lies within 0..63 and 0..47, and RUN resumes.
- Head at x = 63 moving RIGHT, one tick -> o_game_over = 1 and the body is frozen. i_start -> IDLE values restored, o_score = 0.
- Grow to length 5, then press up, left, down in successive ticks -> head hits its own body -> OVER.
- Assert i_Rst during PLACE -> the next cycle shows the reset values and state IDLE.

Source files
------------

// File: rtl/snake_engine.sv
// Snake game-logic stage: worm movement, growth, collisions and item placement.
// Feeds packed segment coordinates, item cell and length to the VGA renderer.
module snake_engine #(
  parameter int MAX_LEN  = 64,
  parameter int TICK_DIV = 5000000,
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 48
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_start,
  input  logic                 i_btn_up,
  input  logic                 i_btn_down,
  input  logic                 i_btn_left,
  input  logic                 i_btn_right,
  output logic [6*MAX_LEN-1:0] o_worm_x,
  output logic [6*MAX_LEN-1:0] o_worm_y,
  output logic [5:0]           o_item_x,
  output logic [5:0]           o_item_y,
  output logic [9:0]           o_size,
  output logic [9:0]           o_score,
  output logic                 o_game_over
);

  localparam int SW = 6*MAX_LEN;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV-1);
  localparam logic [SW-1:0] INIT_X = SW'({6'd30, 6'd31, 6'd32});
  localparam logic [SW-1:0] INIT_Y = SW'({6'd24, 6'd24, 6'd24});

  localparam logic [1:0] D_RIGHT = 2'd0;
  localparam logic [1:0] D_LEFT  = 2'd1;
  localparam logic [1:0] D_UP    = 2'd2;
  localparam logic [1:0] D_DOWN  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PLACE,
    S_OVER
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_worm_x;
  logic [SW-1:0]   r_worm_y;
  logic [5:0]      r_item_x;
  logic [5:0]      r_item_y;
  logic [9:0]      r_size;
  logic [9:0]      r_score;
  logic            r_over;
  logic [1:0]      r_dir;
  logic [1:0]      r_pend;
  logic [CW-1:0]   r_tick;
  logic [11:0]     r_lfsr;

  logic            w_fb;
  logic            w_btn;
  logic [1:0]      w_req;
  logic            w_req_ok;
  logic [1:0]      w_mdir;
  logic [5:0]      w_hx;
  logic [5:0]      w_hy;
  logic [5:0]      w_nx;
  logic [5:0]      w_ny;
  logic            w_wall;
  logic            w_eat;
  logic            w_grow;
  logic            w_self;
  logic [5:0]      w_cx;
  logic [5:0]      w_cy;
  logic            w_hit;
  logic            w_reload;

  assign w_fb = r_lfsr[11] ^ r_lfsr[10] ^ r_lfsr[9] ^ r_lfsr[3];
  assign w_hx = r_worm_x[5:0];
  assign w_hy = r_worm_y[5:0];
  assign w_btn = i_btn_up | i_btn_down | i_btn_left | i_btn_right;

  always_comb begin
    w_req = D_RIGHT;
    if (i_btn_up)        w_req = D_UP;
    else if (i_btn_down) w_req = D_DOWN;
    else if (i_btn_left) w_req = D_LEFT;
  end

  // Opposite directions differ only in bit 0.
  assign w_req_ok = w_btn && (w_req != (r_dir ^ 2'b01));
  assign w_mdir = w_req_ok ? w_req : r_pend;

  always_comb begin
    w_nx = w_hx;
    w_ny = w_hy;
    w_wall = 1'b0;
    unique case (w_mdir)
      D_RIGHT: begin
        w_wall = (w_hx == 6'(GRID_W-1));
        w_nx = w_hx + 6'd1;
      end
      D_LEFT: begin
        w_wall = (w_hx == 6'd0);
        w_nx = w_hx - 6'd1;
      end
      D_UP: begin
        w_wall = (w_hy == 6'd0);
        w_ny = w_hy - 6'd1;
      end
      D_DOWN: begin
        w_wall = (w_hy == 6'(GRID_H-1));
        w_ny = w_hy + 6'd1;
      end
    endcase
  end

  assign w_eat = (w_nx == r_item_x) && (w_ny == r_item_y);
  assign w_grow = w_eat && (r_size < 10'(MAX_LEN));

  assign w_cx = r_lfsr[5:0];
  assign w_cy = (r_lfsr[11:6] < 6'(GRID_H)) ? r_lfsr[11:6]
                                            : r_lfsr[11:6] - 6'd16;

  // The tail only vacates its cell when the worm does not grow.
  always_comb begin
    w_self = 1'b0;
    w_hit = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (r_worm_x[6*k +: 6] == w_nx && r_worm_y[6*k +: 6] == w_ny &&
          ((10'(k) + 10'd2 <= r_size) ||
           (w_grow && (10'(k) + 10'd1 == r_size))))
        w_self = 1'b1;
      if (r_worm_x[6*k +: 6] == w_cx && r_worm_y[6*k +: 6] == w_cy &&
          (10'(k) < r_size))
        w_hit = 1'b1;
    end
  end

  assign w_reload = i_Rst || (r_state == S_OVER && i_start);

  always_ff @(posedge i_Clk) begin
    r_lfsr <= i_Rst ? 12'hACE : {r_lfsr[10:0], w_fb};
    if (w_reload) begin
      r_state  <= S_IDLE;
      r_worm_x <= INIT_X;
      r_worm_y <= INIT_Y;
      r_item_x <= 6'd48;
      r_item_y <= 6'd24;
      r_size   <= 10'd3;
      r_score  <= 10'd0;
      r_over   <= 1'b0;
      r_dir    <= D_RIGHT;
      r_pend   <= D_RIGHT;
      r_tick   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_req_ok) r_pend <= w_req;
          if (r_tick == TICK_LAST) begin
            r_tick <= '0;
            r_dir  <= w_mdir;
            r_pend <= w_mdir;
            if (w_wall || w_self) begin
              r_state <= S_OVER;
              r_over  <= 1'b1;
            end else begin
              r_worm_x <= {r_worm_x[SW-7:0], w_nx};
              r_worm_y <= {r_worm_y[SW-7:0], w_ny};
              if (w_grow) r_size <= r_size + 10'd1;
              if (w_eat) begin
                if (r_score != 10'd1023) r_score <= r_score + 10'd1;
                r_state <= S_PLACE;
              end
            end
          end else begin
            r_tick <= r_tick + CW'(1);
          end
        end
        S_PLACE: begin
          if (w_req_ok) r_pend <= w_req;
          if (!w_hit) begin
            r_item_x <= w_cx;
            r_item_y <= w_cy;
            r_state  <= S_RUN;
          end
        end
        S_OVER: begin
        end
      endcase
    end
  end

  assign o_worm_x    = r_worm_x;
  assign o_worm_y    = r_worm_y;
  assign o_item_x    = r_item_x;
  assign o_item_y    = r_item_y;
  assign o_size      = r_size;
  assign o_score     = r_score;
  assign o_game_over = r_over;

endmodule
